// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    EVAL = 2'd1,
    EMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              press;
  } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO for key events; first-word-fall-through output.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output key_event_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, frame debounce, press/release events via FIFO.
//  state | meaning
//  SCAN  | one row low per dwell period, columns sampled on the dwell's last cycle
//  EVAL  | compare frame against previous frame, update stable count
//  EMIT  | walk 16 keys, push an event for each key differing from debounced map
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_COLS-1:0] i_col,
  output logic [NUM_ROWS-1:0] o_row,
  output logic                o_key_valid,
  input  logic                i_key_ready,
  output logic [CODE_W-1:0]   o_key_code,
  output logic                o_key_press,
  output logic                o_any_down,
  output logic                o_overflow,
  input  logic                i_clr_ovf
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int DW       = $clog2(SCAN_DIV);
  localparam int CW       = $clog2(DEBOUNCE + 1);

  state_e              state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [NUM_KEYS-1:0] raw_q, raw_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CODE_W-1:0]   k_q, k_d;
  logic [NUM_ROWS-1:0] row_out_q, row_out_d;
  logic                any_down_q;
  logic                ovf_q;

  logic       push;
  key_event_t push_evt;
  key_event_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       ovf_set;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    raw_d     = raw_q;
    prev_d    = prev_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    push      = 1'b0;
    push_evt  = '0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          for (int c = 0; c < NUM_COLS; c++) raw_d[{row_q, 2'(c)}] = ~i_col[c];
          row_d = row_q + 2'd1;
          if (row_q == 2'(NUM_ROWS - 1)) state_d = EVAL;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      EVAL: begin
        if (raw_q != prev_q) begin
          prev_d = raw_q;
          cnt_d  = CW'(1);
        end else if (int'(cnt_q) < DEBOUNCE) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (int'(cnt_d) >= DEBOUNCE && raw_q != deb_q) begin
          state_d = EMIT;
          k_d     = '0;
        end else begin
          state_d = SCAN;
        end
      end
      EMIT: begin
        // Debounced bit follows raw even if the FIFO drops the event.
        if (raw_q[k_q] != deb_q[k_q]) begin
          push           = 1'b1;
          push_evt.code  = k_q;
          push_evt.press = raw_q[k_q];
          deb_d[k_q]     = raw_q[k_q];
        end
        k_d = k_q + CODE_W'(1);
        if (k_q == CODE_W'(NUM_KEYS - 1)) state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
    row_out_d = (state_d == SCAN) ? ~(NUM_ROWS'(1) << row_d) : '1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= SCAN;
      row_q      <= '0;
      dwell_q    <= '0;
      raw_q      <= '0;
      prev_q     <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      row_out_q  <= '1;
      any_down_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      raw_q      <= raw_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      row_out_q  <= row_out_d;
      any_down_q <= |deb_q;
      ovf_q      <= ovf_set | (ovf_q & ~i_clr_ovf);
    end
  end

  assign pop     = ~fifo_empty & i_key_ready;
  assign ovf_set = push & fifo_full & ~pop;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_row       = row_out_q;
  assign o_key_valid = ~fifo_empty;
  assign o_key_code  = head.code;
  assign o_key_press = head.press;
  assign o_any_down  = any_down_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_col;
  logic [3:0]  o_row;
  logic        o_key_valid;
  logic        i_key_ready = 1'b1;
  logic [3:0]  o_key_code;
  logic        o_key_press;
  logic        o_any_down;
  logic        o_overflow;
  logic        i_clr_ovf = 1'b0;
  logic [15:0] keys = 16'h0000;

  int n_vec = 0;
  int n_bad = 0;
  logic [4:0] evq[$];

  always #5 i_clk = ~i_clk;

  // Pressed key shorts its row strobe onto its column line.
  always_comb begin
    i_col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!o_row[r] && keys[4*r+c]) i_col[c] = 1'b0;
  end

  keypad_scan_ctrl #(
    .SCAN_DIV   (4),
    .DEBOUNCE   (3),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_col       (i_col),
    .o_row       (o_row),
    .o_key_valid (o_key_valid),
    .i_key_ready (i_key_ready),
    .o_key_code  (o_key_code),
    .o_key_press (o_key_press),
    .o_any_down  (o_any_down),
    .o_overflow  (o_overflow),
    .i_clr_ovf   (i_clr_ovf)
  );

  // Inputs only change just after rising edges, so valid&ready here is the accept.
  always @(negedge i_clk)
    if (!i_rst && o_key_valid && i_key_ready) evq.push_back({o_key_code, o_key_press});

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          n_ev;
    logic [4:0]  ev0;
    logic [4:0]  ev1;
    logic        any;
  } step_t;

  localparam int NSTEP = 15;
  step_t steps[NSTEP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_frame_start();
    int t = 0;
    while (o_row == 4'b1110 && t < 200) begin tick(1); t++; end
    while (o_row != 4'b1110 && t < 200) begin tick(1); t++; end
    if (t >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_timeout: row strobe stuck at %b, required 1110 within 200 cycles", o_row);
    end
  endtask

  // New keys land before row 0 is sampled, so the current frame counts as frame 1.
  task automatic run_step(input logic [15:0] k, input int frames);
    keys = k;
    for (int f = 0; f < frames; f++) wait_frame_start();
    tick(2);
  endtask

  function automatic logic [31:0] ev_at(input int i);
    return (evq.size() > i) ? {27'd0, evq[i]} : 32'hdead;
  endfunction

  initial begin
    logic [3:0] exp_row;
    int t;
    logic [4:0] drain_exp[4];

    steps[0]  = '{16'h0000, 2, 0, 5'b00000, 5'b00000, 1'b0};
    steps[1]  = '{16'h0200, 3, 1, 5'b10011, 5'b00000, 1'b1};
    steps[2]  = '{16'h0000, 3, 1, 5'b10010, 5'b00000, 1'b0};
    steps[3]  = '{16'h0001, 1, 0, 5'b00000, 5'b00000, 1'b0};
    steps[4]  = '{16'h0000, 1, 0, 5'b00000, 5'b00000, 1'b0};
    steps[5]  = '{16'h0001, 1, 0, 5'b00000, 5'b00000, 1'b0};
    steps[6]  = '{16'h0000, 1, 0, 5'b00000, 5'b00000, 1'b0};
    steps[7]  = '{16'h0001, 1, 0, 5'b00000, 5'b00000, 1'b0};
    steps[8]  = '{16'h0001, 1, 0, 5'b00000, 5'b00000, 1'b0};
    steps[9]  = '{16'h0001, 1, 1, 5'b00001, 5'b00000, 1'b1};
    steps[10] = '{16'h0000, 3, 1, 5'b00000, 5'b00000, 1'b0};
    steps[11] = '{16'h1008, 3, 2, 5'b00111, 5'b11001, 1'b1};
    steps[12] = '{16'h0000, 3, 2, 5'b00110, 5'b11000, 1'b0};
    steps[13] = '{16'h0020, 2, 0, 5'b00000, 5'b00000, 1'b0};
    steps[14] = '{16'h0000, 3, 0, 5'b00000, 5'b00000, 1'b0};

    drain_exp[0] = 5'b00011;
    drain_exp[1] = 5'b00101;
    drain_exp[2] = 5'b01001;
    drain_exp[3] = 5'b00010;

    // Reset values
    tick(3);
    check("rst_row", o_row, 4'b1111);
    check("rst_valid", o_key_valid, 0);
    check("rst_code", o_key_code, 0);
    check("rst_press", o_key_press, 0);
    check("rst_any", o_any_down, 0);
    check("rst_ovf", o_overflow, 0);
    i_rst = 1'b0;

    // Idle row sequence over one full frame
    wait_frame_start();
    wait_frame_start();
    for (int i = 0; i < 17; i++) begin
      exp_row = (i < 16) ? ~(4'b0001 << (i / 4)) : 4'b1111;
      check($sformatf("idle_row%0d", i), o_row, exp_row);
      tick(1);
    end
    check("idle_valid", o_key_valid, 0);
    check("idle_any", o_any_down, 0);

    for (int i = 0; i < NSTEP; i++) begin
      evq.delete();
      run_step(steps[i].keys, steps[i].frames);
      check($sformatf("step%0d_nev", i), evq.size(), steps[i].n_ev);
      if (steps[i].n_ev > 0) check($sformatf("step%0d_ev0", i), ev_at(0), steps[i].ev0);
      if (steps[i].n_ev > 1) check($sformatf("step%0d_ev1", i), ev_at(1), steps[i].ev1);
      check($sformatf("step%0d_any", i), o_any_down, steps[i].any);
    end

    // FIFO overflow with the consumer stalled
    i_key_ready = 1'b0;
    evq.delete();
    run_step(16'h0016, 3);
    check("ovf_press_nev", evq.size(), 0);
    check("ovf_press_valid", o_key_valid, 1);
    check("ovf_press_head", {o_key_code, o_key_press}, 5'b00011);
    check("ovf_press_flag", o_overflow, 0);
    check("ovf_press_any", o_any_down, 1);
    run_step(16'h0000, 3);
    check("ovf_rel_head", {o_key_code, o_key_press}, 5'b00011);
    check("ovf_rel_flag", o_overflow, 1);
    check("ovf_rel_any", o_any_down, 0);
    i_key_ready = 1'b1;
    tick(10);
    check("drain_n", evq.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("drain_ev%0d", i), ev_at(i), drain_exp[i]);
    check("drain_valid", o_key_valid, 0);
    check("drain_ovf_sticky", o_overflow, 1);
    i_clr_ovf = 1'b1;
    tick(1);
    i_clr_ovf = 1'b0;
    check("clr_ovf", o_overflow, 0);

    // Reset in the middle of EMIT with events queued
    i_key_ready = 1'b0;
    wait_frame_start();
    keys = 16'h1008;
    wait_frame_start();
    wait_frame_start();
    t = 0;
    while (!o_key_valid && t < 100) begin tick(1); t++; end
    check("mid_emit_valid", o_key_valid, 1);
    tick(1);
    i_rst = 1'b1;
    #1;
    check("midrst_valid", o_key_valid, 0);
    check("midrst_row", o_row, 4'b1111);
    check("midrst_code", o_key_code, 0);
    check("midrst_any", o_any_down, 0);
    tick(1);
    check("midrst_row_hold", o_row, 4'b1111);
    keys = 16'h0000;
    tick(2);
    evq.delete();
    i_key_ready = 1'b1;
    i_rst = 1'b0;
    run_step(16'h0000, 4);
    check("restart_idle_nev", evq.size(), 0);
    check("restart_idle_any", o_any_down, 0);
    evq.delete();
    run_step(16'h0040, 3);
    check("restart_nev", evq.size(), 1);
    check("restart_ev0", ev_at(0), 5'b01101);
    check("restart_any", o_any_down, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 500000ns");
    $fatal(1);
  end

endmodule
